// File: rtl/gr_cordic.sv
// Rotation-mode Givens CORDIC cell: applies a streamed direction-bit sequence to one (x, y) pair.
// Define GR_SCALE_EN to apply the K gain compensation in SCALE; otherwise the raw CORDIC gain remains.
module gr_cordic #(
  parameter int DATA_WIDTH = 20,
  parameter int D_WIDTH    = 4,
  parameter int ITER       = 12,
  parameter int K_WIDTH    = 11,
  parameter logic signed [K_WIDTH-1:0] K = 11'b0_1001101101
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] x_i,
  input  logic [DATA_WIDTH-1:0] y_i,
  input  logic                  d_valid_i,
  input  logic [D_WIDTH-1:0]    d_i,
  output logic                  busy_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] x_o,
  output logic [DATA_WIDTH-1:0] y_o
);

  localparam int N_CHUNK = ITER / D_WIDTH;
  localparam int CNT_W   = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(N_CHUNK - 1);
  localparam logic signed [DATA_WIDTH-1:0] MAX_V = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] MIN_V = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROT   = 2'd1,
    SCALE = 2'd2
  } state_t;

  state_t                        state_r, state_next_s;
  logic [CNT_W-1:0]              cnt_r, cnt_next_s;
  logic signed [DATA_WIDTH-1:0]  x_r, y_r, x_next_s, y_next_s;
  logic signed [DATA_WIDTH-1:0]  x_rot_s, y_rot_s;
  logic signed [DATA_WIDTH-1:0]  x_scaled_s, y_scaled_s;
  logic                          load_out_s;

  // Clamp a one-bit-wider intermediate back into the signed data range.
  function automatic logic signed [DATA_WIDTH-1:0] sat_f(input logic signed [DATA_WIDTH:0] v);
    logic signed [DATA_WIDTH-1:0] r;
    if (v[DATA_WIDTH] != v[DATA_WIDTH-1]) begin
      if (v[DATA_WIDTH]) begin
        r = MIN_V;
      end else begin
        r = MAX_V;
      end
    end else begin
      r = v[DATA_WIDTH-1:0];
    end
    return r;
  endfunction

  // Unfolded chain of D_WIDTH micro-rotations for the current chunk.
  always_comb begin
    logic signed [DATA_WIDTH-1:0] xa_v, ya_v, xs_v, ys_v;
    logic signed [DATA_WIDTH:0]   xw_v, yw_v;
    int                           sh_v;
    xa_v = x_r;
    ya_v = y_r;
    xs_v = {DATA_WIDTH{1'b0}};
    ys_v = {DATA_WIDTH{1'b0}};
    xw_v = {(DATA_WIDTH+1){1'b0}};
    yw_v = {(DATA_WIDTH+1){1'b0}};
    sh_v = 0;
    for (int j = 0; j < D_WIDTH; j++) begin
      sh_v = int'(cnt_r) * D_WIDTH + j;
      xs_v = xa_v >>> sh_v;
      ys_v = ya_v >>> sh_v;
      if (d_i[j]) begin
        xw_v = {xa_v[DATA_WIDTH-1], xa_v} + {ys_v[DATA_WIDTH-1], ys_v};
        yw_v = {ya_v[DATA_WIDTH-1], ya_v} - {xs_v[DATA_WIDTH-1], xs_v};
      end else begin
        xw_v = {xa_v[DATA_WIDTH-1], xa_v} - {ys_v[DATA_WIDTH-1], ys_v};
        yw_v = {ya_v[DATA_WIDTH-1], ya_v} + {xs_v[DATA_WIDTH-1], xs_v};
      end
      xa_v = sat_f(xw_v);
      ya_v = sat_f(yw_v);
    end
    x_rot_s = xa_v;
    y_rot_s = ya_v;
  end

`ifdef GR_SCALE_EN
  localparam int FRAC = K_WIDTH - 1;
  localparam int PW   = DATA_WIDTH + K_WIDTH;
  logic [PW-1:0] prod_x_s, prod_y_s;
  logic          unused_s;

  // Sign-extended operands make the truncated unsigned product equal the signed one.
  assign prod_x_s   = {{K_WIDTH{x_r[DATA_WIDTH-1]}}, x_r} * {{DATA_WIDTH{K[K_WIDTH-1]}}, K};
  assign prod_y_s   = {{K_WIDTH{y_r[DATA_WIDTH-1]}}, y_r} * {{DATA_WIDTH{K[K_WIDTH-1]}}, K};
  assign x_scaled_s = prod_x_s[DATA_WIDTH+FRAC-1:FRAC];
  assign y_scaled_s = prod_y_s[DATA_WIDTH+FRAC-1:FRAC];
  assign unused_s   = ^{prod_x_s[PW-1:DATA_WIDTH+FRAC], prod_x_s[FRAC-1:0],
                        prod_y_s[PW-1:DATA_WIDTH+FRAC], prod_y_s[FRAC-1:0]};
`else
  logic [K_WIDTH-1:0] unused_k_s;

  assign x_scaled_s = x_r;
  assign y_scaled_s = y_r;
  assign unused_k_s = K;
`endif

  // Next-state, chunk counter and working-register update; clr_i overrides everything.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    x_next_s     = x_r;
    y_next_s     = y_r;
    load_out_s   = 1'b0;
    if (clr_i) begin
      state_next_s = IDLE;
      cnt_next_s   = {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (valid_i) begin
            state_next_s = ROT;
            cnt_next_s   = {CNT_W{1'b0}};
            x_next_s     = x_i;
            y_next_s     = y_i;
          end else begin
            state_next_s = IDLE;
          end
        end
        ROT: begin
          if (d_valid_i) begin
            x_next_s = x_rot_s;
            y_next_s = y_rot_s;
            if (cnt_r == LAST_CHUNK) begin
              state_next_s = SCALE;
              cnt_next_s   = {CNT_W{1'b0}};
            end else begin
              cnt_next_s   = cnt_r + CNT_W'(1);
            end
          end else begin
            state_next_s = ROT;
          end
        end
        SCALE: begin
          load_out_s   = 1'b1;
          state_next_s = IDLE;
        end
        default: begin
          state_next_s = IDLE;
          cnt_next_s   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // State, working registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      x_r     <= {DATA_WIDTH{1'b0}};
      y_r     <= {DATA_WIDTH{1'b0}};
      busy_o  <= 1'b0;
      valid_o <= 1'b0;
      x_o     <= {DATA_WIDTH{1'b0}};
      y_o     <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      x_r     <= x_next_s;
      y_r     <= y_next_s;
      busy_o  <= (state_next_s != IDLE);
      valid_o <= load_out_s;
      if (load_out_s) begin
        x_o <= x_scaled_s;
        y_o <= y_scaled_s;
      end
    end
  end

endmodule

// File: tb/tb_gr_cordic.sv
// Directed scoreboard bench for gr_cordic; honours GR_SCALE_EN for the expected gain.
module tb_gr_cordic;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr_i = 1'b0;
  logic        valid_i = 1'b0;
  logic [19:0] x_i = 20'd0;
  logic [19:0] y_i = 20'd0;
  logic        d_valid_i = 1'b0;
  logic [3:0]  d_i = 4'd0;
  logic        busy_o, valid_o;
  logic [19:0] x_o, y_o;

  typedef struct { int x; int y; } pair_t;

  int    total = 0;
  int    bad = 0;
  int    vcount = 0;
  int    vc0;
  pair_t exp_q[$];
  pair_t last_exp;
  logic [11:0] d_loop, d_small;

  gr_cordic dut (
    .clk(clk), .rst(rst), .clr_i(clr_i), .valid_i(valid_i),
    .x_i(x_i), .y_i(y_i), .d_valid_i(d_valid_i), .d_i(d_i),
    .busy_o(busy_o), .valid_o(valid_o), .x_o(x_o), .y_o(y_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid_o === 1'b1) vcount++;
  end

  function automatic int clamp(input int v);
    if (v > 524287) return 524287;
    if (v < -524288) return -524288;
    return v;
  endfunction

  function automatic pair_t rotate(input int x0, input int y0, input logic [11:0] d);
    pair_t p;
    int x, y, tx;
    x = x0; y = y0;
    for (int i = 0; i < 12; i++) begin
      tx = x;
      if (d[i]) begin
        x = clamp(x + (y >>> i));
        y = clamp(y - (tx >>> i));
      end else begin
        x = clamp(x - (y >>> i));
        y = clamp(y + (tx >>> i));
      end
    end
    p.x = x; p.y = y;
    return p;
  endfunction

  function automatic logic [11:0] vec_dirs(input int x0, input int y0);
    logic [11:0] d;
    int x, y, tx;
    x = x0; y = y0; d = 12'd0;
    for (int i = 0; i < 12; i++) begin
      tx = x;
      d[i] = (y >= 0);
      if (d[i]) begin
        x = clamp(x + (y >>> i));
        y = clamp(y - (tx >>> i));
      end else begin
        x = clamp(x - (y >>> i));
        y = clamp(y + (tx >>> i));
      end
    end
    return d;
  endfunction

  function automatic int scale(input int v);
`ifdef GR_SCALE_EN
    return (v * 621) >>> 10;
`else
    return v;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input logic signed [31:0] obs, input logic signed [31:0] expv, input string tag);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_near(input logic signed [31:0] obs, input int expv, input int tol, input string tag);
    total++;
    assert ((obs >= expv - tol) && (obs <= expv + tol)) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d+-%0d", tag, obs, expv, tol);
    end
  endtask

  task automatic start_op(input int x, input int y, input logic [11:0] d, input bit push, input bit drop_chunk);
    pair_t r, e;
    if (push) begin
      r = rotate(x, y, d);
      e.x = scale(r.x);
      e.y = scale(r.y);
      exp_q.push_back(e);
    end
    x_i = x[19:0];
    y_i = y[19:0];
    valid_i = 1'b1;
    if (drop_chunk) begin
      d_valid_i = 1'b1;
      d_i = ~d[3:0];
    end
    tick();
    valid_i = 1'b0;
    d_valid_i = 1'b0;
    chk(busy_o, 1, "busy_after_load");
  endtask

  task automatic send_chunks(input logic [11:0] d, input int gap, input bit junk_valid);
    for (int c = 0; c < 3; c++) begin
      d_valid_i = 1'b1;
      d_i = d[c*4 +: 4];
      tick();
      d_valid_i = 1'b0;
      if (c < 2) begin
        for (int g = 0; g < gap; g++) begin
          if (junk_valid && g == 0) begin
            valid_i = 1'b1;
            x_i = 20'h12345;
            y_i = 20'h54321;
          end
          tick();
          valid_i = 1'b0;
        end
      end
    end
  endtask

  task automatic finish_op(input string tag, input bit junk_in_scale);
    pair_t e;
    chk(valid_o, 0, {tag, "_no_early_valid"});
    chk(busy_o, 1, {tag, "_busy_in_scale"});
    if (junk_in_scale) begin
      valid_i = 1'b1;
      x_i = 20'h0ABCD;
      y_i = 20'h0DCBA;
    end
    tick();
    valid_i = 1'b0;
    chk(valid_o, 1, {tag, "_valid"});
    chk(busy_o, 0, {tag, "_busy_done"});
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_queue: observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk($signed(x_o), e.x, {tag, "_x"});
      chk($signed(y_o), e.y, {tag, "_y"});
      last_exp = e;
    end
  endtask

  initial begin
    repeat (2) tick();
    chk(busy_o, 0, "rst_busy");
    chk(valid_o, 0, "rst_valid");
    chk(x_o, 0, "rst_x");
    chk(y_o, 0, "rst_y");
    rst = 1'b0;
    tick();

    // Loopback with vectoring-generated directions, back-to-back chunks.
    d_loop = vec_dirs(30000, 40000);
    start_op(30000, 40000, d_loop, 1'b1, 1'b0);
    send_chunks(d_loop, 0, 1'b0);
    finish_op("loop", 1'b0);
`ifdef GR_SCALE_EN
    chk_near($signed(x_o), 49935, 16, "loop_x_mag");
    chk_near($signed(y_o), 0, 16, "loop_y_res");
`else
    chk_near($signed(x_o), 82338, 48, "loop_x_mag");
    chk_near($signed(y_o), 0, 48, "loop_y_res");
`endif
    tick();
    chk(valid_o, 0, "strobe_one_cycle");

    // Fixed all-ones direction stream; a chunk arriving with valid_i is dropped.
    start_op(65536, 0, 12'hFFF, 1'b1, 1'b1);
    send_chunks(12'hFFF, 0, 1'b0);
    finish_op("fixed", 1'b0);
`ifdef GR_SCALE_EN
    chk_near($signed(x_o), -11200, 64, "fixed_x_ang");
    chk_near($signed(y_o), -64490, 64, "fixed_y_ang");
`else
    chk_near($signed(x_o), -18470, 128, "fixed_x_ang");
    chk_near($signed(y_o), -106330, 128, "fixed_y_ang");
`endif

    // Gapped stream with ignored inputs in IDLE, ROT gaps and SCALE.
    tick();
    d_valid_i = 1'b1;
    d_i = 4'hF;
    tick();
    d_valid_i = 1'b0;
    chk(busy_o, 0, "idle_dvalid_ignored");
    vc0 = vcount;
    start_op(30000, 40000, d_loop, 1'b1, 1'b0);
    send_chunks(d_loop, 3, 1'b1);
    finish_op("gap", 1'b1);
    repeat (3) tick();
    chk(vcount - vc0, 1, "gap_one_valid");
    chk(busy_o, 0, "gap_idle_after");

    // Saturation on the first micro-step.
    start_op(524287, 524287, 12'h000, 1'b1, 1'b0);
    send_chunks(12'h000, 0, 1'b0);
    finish_op("sat", 1'b0);
    chk_near($signed(y_o), 262144, 262143, "sat_y_positive");

    // Abort after chunk 1.
    tick();
    vc0 = vcount;
    start_op(1000, 0, 12'hFFF, 1'b0, 1'b0);
    d_valid_i = 1'b1; d_i = 4'hF; tick();
    d_valid_i = 1'b1; d_i = 4'hF; tick();
    d_valid_i = 1'b0;
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    chk(busy_o, 0, "clr_busy");
    d_valid_i = 1'b1; d_i = 4'hF; tick();
    d_valid_i = 1'b0;
    repeat (5) tick();
    chk(vcount - vc0, 0, "clr_no_valid");
    chk($signed(x_o), last_exp.x, "clr_x_kept");
    chk($signed(y_o), last_exp.y, "clr_y_kept");

    // clr_i wins over valid_i.
    clr_i = 1'b1;
    valid_i = 1'b1;
    x_i = 20'd5;
    tick();
    clr_i = 1'b0;
    valid_i = 1'b0;
    chk(busy_o, 0, "clr_priority");

    // Asynchronous reset in the middle of ROT.
    start_op(30000, 40000, d_loop, 1'b0, 1'b0);
    d_valid_i = 1'b1; d_i = d_loop[3:0]; tick();
    d_valid_i = 1'b0;
    rst = 1'b1;
    #1;
    chk(busy_o, 0, "midrst_busy");
    chk(valid_o, 0, "midrst_valid");
    chk(x_o, 0, "midrst_x");
    chk(y_o, 0, "midrst_y");
    tick();
    rst = 1'b0;
    tick();

    // Recovery run with a small operand.
    d_small = vec_dirs(1000, 0);
    start_op(1000, 0, d_small, 1'b1, 1'b0);
    send_chunks(d_small, 0, 1'b0);
    finish_op("small", 1'b0);
`ifdef GR_SCALE_EN
    chk_near($signed(x_o), 999, 4, "small_x_mag");
`else
    chk_near($signed(x_o), 1647, 4, "small_x_mag");
`endif
    chk_near($signed(y_o), 0, 4, "small_y_res");

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gr_cordic.md
# gr_cordic

Givens-rotation (GR) CORDIC cell for the QR-decomposition array, running in rotation mode. It receives the direction-bit stream produced by the vectoring (Givens-generation) cell of the same row. It applies those micro-rotations to one (x, y) element pair, using the same 4-way unfolded iteration schedule, and applies the K gain compensation. The result is the rotated pair, which goes to the next row or to the R output.

## Interface
- `DATA_WIDTH`, 20: signed two's-complement width of x/y data.
- `D_WIDTH`, 4: direction bits per chunk, i.e. micro-rotations per clock (unfold factor).
- `ITER`, 12: total micro-rotations; must be a multiple of `D_WIDTH`.
- `K_WIDTH`, 11: width of the gain constant.
- `K`, 11'b0_1001101101: CORDIC gain compensation, signed Q1.10 (≈0.6064).

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clr_i`  in  1  synchronous abort; returns to IDLE.
- `valid_i`  in  1  load strobe for `x_i`/`y_i`.
- `x_i`  in  DATA_WIDTH  signed x operand.
- `y_i`  in  DATA_WIDTH  signed y operand.
- `d_valid_i`  in  1  `d_i` carries the next chunk.
- `d_i`  in  D_WIDTH  direction bits; bit j = iteration 4c+j of chunk c.
- `busy_o`  out  1  high in ROT and SCALE.
- `valid_o`  out  1  one-cycle result strobe.
- `x_o`  out  DATA_WIDTH  rotated, scaled x.
- `y_o`  out  DATA_WIDTH  rotated, scaled y.

## Operation
- FSM states: IDLE, ROT, SCALE.
- IDLE → ROT on `valid_i`.
  - Capture `x_i`/`y_i` into the working registers.
  - Clear the chunk counter `c`.
- ROT:
  - On each `d_valid_i`, apply `D_WIDTH` combinational micro-steps in chunk c.
  - Step j uses shift s = 4c+j.
  - If d=1: x' = x + (y>>>s), y' = y − (x>>>s).
  - If d=0: x' = x − (y>>>s), y' = y + (x>>>s).
  - `>>>` is an arithmetic shift.
  - Each step is computed at DATA_WIDTH+1 bits and saturated to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1] before feeding the next step.
  - `c` increments per chunk. After chunk ITER/D_WIDTH−1 → SCALE.
  - Cycles with `d_valid_i` low: hold state and data; gaps of any length are allowed.
- SCALE:
  - Compute product = x·K and y·K, signed, DATA_WIDTH+K_WIDTH bits.
  - Result = product[DATA_WIDTH+9:10], i.e. >>>10 with truncation toward −∞. Since |K|<1, no overflow is possible.
  - Register the result into `x_o`/`y_o`, pulse `valid_o`, → IDLE.
- `x_o`/`y_o` hold their value until the next result.
- `valid_i` while `busy_o`=1: ignored; the operation in flight is unaffected.
- `d_valid_i` in IDLE or SCALE: ignored.
- `valid_i` together with `d_valid_i` in IDLE: load only; the chunk is dropped.
- `clr_i`:
  - Has priority over `valid_i`/`d_valid_i`.
  - Any state → IDLE, counter cleared.
  - `x_o`/`y_o` are kept and `valid_o` is not asserted.
- `rst`, including mid-operation: state IDLE, counter 0, working regs 0, `x_o`=`y_o`=0, `valid_o`=0, `busy_o`=0.

## Timing
- `valid_i` sampled at edge 0.
- Chunks sampled at edges t1 < t2 < t3.
- SCALE occupies the cycle after t3.
- `valid_o`=1 in the cycle after SCALE, i.e. 2 cycles after the last chunk's sampling edge.
- Back-to-back stream (chunks in cycles 1, 2, 3): `valid_o` is high in cycle 5.
- Latency from `valid_i` to `valid_o`: 5 cycles minimum.
- Throughput: a new `valid_i` is accepted in the cycle `valid_o` is high (state is IDLE). Peak is one pair per 5 cycles.
- `busy_o` is registered; it is high from the cycle after `valid_i` through the SCALE cycle.

## Configuration
- `GR_SCALE_EN` defined: SCALE multiplies by `K` as described above.
- `GR_SCALE_EN` undefined:
  - SCALE passes the working x/y unscaled; the multipliers are removed.
  - Latency and handshake are identical.
  - Outputs carry the CORDIC gain ≈1.6468.

## Test plan
- Reset/idle:
  - Stimulus: assert `rst` mid-ROT.
  - Response: `busy_o`=0, `valid_o`=0, `x_o`=`y_o`=0 immediately. The next `valid_i`/stream produces a correct result.
- Loopback with the vectoring cell:
  - Stimulus: direction bits from vectoring (x=30000, y=40000), back-to-back, applied to (30000, 40000).
  - Response: `valid_o` in cycle 5; `x_o`≈49935±16, |`y_o`|≤16.
- Fixed direction stream:
  - Stimulus: (65536, 0), all d=1.
  - Response: net clockwise angle 1.7428 rad; `x_o`≈−11200±64, `y_o`≈−64490±64.
- Gapped stream plus ignored inputs:
  - Stimulus: chunks with 3-cycle gaps; extra `valid_i` while busy; `d_valid_i` in IDLE.
  - Response: result identical to back-to-back; `valid_o` 2 cycles after the last chunk; exactly one `valid_o`.
- Saturation:
  - Stimulus: (0x7FFFF, 0x7FFFF), all d=0.
  - Response: the first step saturates y to 0x7FFFF with no sign wrap; `y_o`>0, `x_o` bounded.
- `clr_i` and macro off:
  - Stimulus (a): `clr_i` after chunk 1. Response: no `valid_o`, `x_o`/`y_o` unchanged.
  - Stimulus (b): with `GR_SCALE_EN` undefined, (1000, 0), loopback d bits from vectoring (1000, 0). Response: `x_o`≈1647±4, `y_o`≈0±4.
